// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master block.
// Contents: default frame width and clock divider, FSM state type,
// and a helper that tells whether a state keeps the slave selected.
package spi_pkg;

    localparam int SPI_DATA_W_DEF  = 16;
    localparam int SPI_CLK_DIV_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_XFER  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } spi_state_t;

    // True for the states in which chip select is asserted and MOSI carries frame data.
    function automatic logic frame_active(input spi_state_t st);
        logic act;
        case (st)
            ST_SETUP, ST_XFER, ST_HOLD: act = 1'b1;
            default:                    act = 1'b0;
        endcase
        return act;
    endfunction

endpackage

// File: rtl/spi_master_if.sv
// Bus bundle between the SPI master and its user / the SPI slave.
// Signals:
//   start, tx_data       - frame request and word to send (user -> master)
//   busy, done, rx_data  - frame status and received word (master -> user)
//   spi_sclk, spi_mosi, spi_cs_n - SPI outputs (master -> slave)
//   spi_miso             - SPI input (slave -> master)
// Modports: master (the DUT view) and slave (the user/slave side view).
interface spi_master_if #(
    parameter int DATA_W = spi_pkg::SPI_DATA_W_DEF
);
    logic              start;
    logic [DATA_W-1:0] tx_data;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rx_data;
    logic              spi_sclk;
    logic              spi_mosi;
    logic              spi_miso;
    logic              spi_cs_n;

    modport master (
        input  start, tx_data, spi_miso,
        output busy, done, rx_data, spi_sclk, spi_mosi, spi_cs_n
    );

    modport slave (
        output start, tx_data, spi_miso,
        input  busy, done, rx_data, spi_sclk, spi_mosi, spi_cs_n
    );
endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Ports: clk, rst_n (async active-low, resets to 0), d_i (async in), q_o (synchronized out).
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);
    logic [1:0] sync_q;

    // Shift the async bit through two flops to settle metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];
endmodule

// File: rtl/spi_master.sv
// SPI master, mode 0 (CPOL=0, CPHA=0), MSB first, one frame per start.
// Ports:
//   clk      - system clock, all state on its rising edge
//   reset_n  - asynchronous active-low reset
//   bus      - spi_master_if.master: start/tx_data in, busy/done/rx_data out,
//              spi_sclk/spi_mosi/spi_cs_n out, spi_miso in
// Frame sequence: IDLE -> SETUP -> XFER -> HOLD -> GAP -> IDLE, each phase a
// multiple of CLK_DIV clk cycles. All outputs are registered.
module spi_master
    import spi_pkg::*;
#(
    parameter int DATA_W  = SPI_DATA_W_DEF,
    parameter int CLK_DIV = SPI_CLK_DIV_DEF
) (
    input  logic         clk,
    input  logic         reset_n,
    spi_master_if.master bus
);
    // Widths sized so that neither counter can overflow for any legal parameter.
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int BIT_W = $clog2(2 * DATA_W + 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] HALF_LAST = BIT_W'(2 * DATA_W - 1);

    spi_state_t        state_q,   state_d;
    logic [DIV_W-1:0]  div_q,     div_d;
    logic [BIT_W-1:0]  half_q,    half_d;
    logic [DATA_W-1:0] tx_sh_q,   tx_sh_d;
    logic [DATA_W-1:0] rx_sh_q,   rx_sh_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              sclk_q,    sclk_d;
    logic              mosi_q,    mosi_d;
    logic              cs_n_q,    cs_n_d;
    logic              busy_q,    busy_d;
    logic              done_q,    done_d;
    logic              miso_sync_s;
    logic              div_end_s;

    sync2 u_miso_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d_i   (bus.spi_miso),
        .q_o   (miso_sync_s)
    );

    assign div_end_s = (div_q == DIV_LAST);

    // Next-state, counter, shift-register and output computation.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q + DIV_W'(1);
        half_d    = half_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        sclk_d    = sclk_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                div_d  = '0;
                half_d = '0;
                sclk_d = 1'b0;
                if (bus.start) begin
                    state_d = ST_SETUP;
                    tx_sh_d = bus.tx_data;
                    rx_sh_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (div_end_s) begin
                    state_d = ST_XFER;
                    div_d   = '0;
                end else begin
                    state_d = ST_SETUP;
                end
            end
            ST_XFER: begin
                if (div_end_s) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        // Rising edge: sample the slave bit.
                        rx_sh_d = {rx_sh_q[DATA_W-2:0], miso_sync_s};
                    end else if (half_q != HALF_LAST) begin
                        // Falling edge (not the last): present the next bit.
                        tx_sh_d = {tx_sh_q[DATA_W-2:0], 1'b0};
                    end else begin
                        tx_sh_d = tx_sh_q;
                    end
                    if (half_q == HALF_LAST) begin
                        state_d = ST_HOLD;
                        half_d  = '0;
                    end else begin
                        half_d  = half_q + BIT_W'(1);
                    end
                end else begin
                    state_d = ST_XFER;
                end
            end
            ST_HOLD: begin
                if (div_end_s) begin
                    state_d   = ST_GAP;
                    div_d     = '0;
                    rx_data_d = rx_sh_q;
                    done_d    = 1'b1;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_GAP: begin
                // start is deliberately not looked at here: guarantees CS-high time.
                if (div_end_s) begin
                    state_d = ST_IDLE;
                    div_d   = '0;
                end else begin
                    state_d = ST_GAP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                div_d   = '0;
                half_d  = '0;
                sclk_d  = 1'b0;
            end
        endcase

        // Outputs follow the next state so they change on the same edge as the state.
        if (frame_active(state_d)) begin
            cs_n_d = 1'b0;
            mosi_d = tx_sh_d[DATA_W-1];
        end else begin
            cs_n_d = 1'b1;
            mosi_d = 1'b0;
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State, counters, shift registers and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            div_q     <= '0;
            half_q    <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            half_q    <= half_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.spi_sclk = sclk_q;
    assign bus.spi_mosi = mosi_q;
    assign bus.spi_cs_n = cs_n_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master at DATA_W=16, CLK_DIV=4.
// Table of frames (loopback / constant MISO) plus hand sequences for the
// slave response, start-while-busy, mid-frame reset and held start.
module tb_spi_master;
    localparam int DW  = 16;
    localparam int DIV = 4;
    localparam int LAT = DIV * (2 * DW + 2) + 1;

    logic clk;
    logic reset_n;
    int   n_checks = 0;
    int   n_errors = 0;

    // MISO source: 0 = loopback from MOSI, 1 = constant, 2 = slave model.
    int   miso_mode  = 0;
    logic miso_const = 1'b0;

    logic [DW-1:0] slv_tx   = '0;
    logic [DW-1:0] slv_rx   = '0;
    logic [DW-1:0] slv_resp = '0;
    logic          slv_sclk_prev = 1'b0;
    logic          slv_cs_prev   = 1'b1;

    spi_master_if #(.DATA_W(DW)) bus ();

    spi_master #(.DATA_W(DW), .CLK_DIV(DIV)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    assign bus.spi_miso = (miso_mode == 0) ? bus.spi_mosi :
                          (miso_mode == 1) ? miso_const   : slv_tx[DW-1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mode-0 slave: load response at CS fall, capture on SCLK rise, shift out on SCLK fall.
    always @(negedge clk) begin
        if (slv_cs_prev && !bus.spi_cs_n) begin
            slv_tx <= slv_resp;
        end else if (slv_sclk_prev && !bus.spi_sclk) begin
            slv_tx <= {slv_tx[DW-2:0], 1'b0};
        end
        if (!slv_sclk_prev && bus.spi_sclk && !bus.spi_cs_n) begin
            slv_rx <= {slv_rx[DW-2:0], bus.spi_mosi};
        end
        slv_sclk_prev <= bus.spi_sclk;
        slv_cs_prev   <= bus.spi_cs_n;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One complete frame from IDLE; optionally pulses start+0xFFFF at cycle pulse_at
    // and optionally releases reset on the same edge that start is raised.
    task automatic run_frame(input string tag, input logic [DW-1:0] tx,
                             input logic [DW-1:0] exp_rx, input int pulse_at,
                             input logic rel_rst);
        int            lat;
        int            rises;
        int            ndone;
        int            done_lat;
        logic          prev_sclk;
        logic [DW-1:0] mosi_w;
        logic [DW-1:0] rx_at_done;
        @(negedge clk);
        if (rel_rst) reset_n = 1'b1;
        bus.start   = 1'b1;
        bus.tx_data = tx;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 1;
        check({tag, "_busy_first"}, 32'(bus.busy), 32'd1);
        check({tag, "_csn_first"},  32'(bus.spi_cs_n), 32'd0);
        check({tag, "_mosi_msb"},   32'(bus.spi_mosi), 32'(tx[DW-1]));
        prev_sclk  = bus.spi_sclk;
        rises      = 0;
        ndone      = 0;
        done_lat   = 0;
        mosi_w     = '0;
        rx_at_done = '0;
        for (int n = 0; n < LAT + 43; n++) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == pulse_at) begin
                bus.start   = 1'b1;
                bus.tx_data = 16'hFFFF;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.spi_sclk && !prev_sclk) begin
                rises++;
                mosi_w = {mosi_w[DW-2:0], bus.spi_mosi};
            end
            prev_sclk = bus.spi_sclk;
            if (bus.done) begin
                ndone++;
                if (done_lat == 0) done_lat = lat;
                rx_at_done = bus.rx_data;
            end
        end
        check({tag, "_done_lat"}, 32'(done_lat), 32'(LAT));
        check({tag, "_ndone"},    32'(ndone), 32'd1);
        check({tag, "_rises"},    32'(rises), 32'(DW));
        check({tag, "_mosi"},     32'(mosi_w), 32'(tx));
        check({tag, "_rx"},       32'(rx_at_done), 32'(exp_rx));
        check({tag, "_rx_hold"},  32'(bus.rx_data), 32'(exp_rx));
        check({tag, "_idle"},     {30'd0, bus.busy, bus.spi_cs_n}, 32'd1);
    endtask

    typedef struct {
        logic [DW-1:0] tx;
        int            mode;
        logic          mc;
        logic [DW-1:0] exp_rx;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int ndone;
        int high_run;
        int gaps;
        int lat;
        logic seen_low;

        vecs[0] = '{16'hA5C3, 0, 1'b0, 16'hA5C3};
        vecs[1] = '{16'h0001, 0, 1'b0, 16'h0001};
        vecs[2] = '{16'h8000, 0, 1'b0, 16'h8000};
        vecs[3] = '{16'h5A5A, 0, 1'b0, 16'h5A5A};
        vecs[4] = '{16'h1234, 1, 1'b1, 16'hFFFF};
        vecs[5] = '{16'hFFFF, 1, 1'b0, 16'h0000};

        reset_n     = 1'b0;
        bus.start   = 1'b0;
        bus.tx_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_csn",  32'(bus.spi_cs_n), 32'd1);
        check("rst_sclk", 32'(bus.spi_sclk), 32'd0);
        check("rst_mosi", 32'(bus.spi_mosi), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_rx",   32'(bus.rx_data), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Table-driven frames.
        for (int i = 0; i < 6; i++) begin
            miso_mode  = vecs[i].mode;
            miso_const = vecs[i].mc;
            run_frame($sformatf("v%0d", i), vecs[i].tx, vecs[i].exp_rx, 0, 1'b0);
        end

        // Slave answers the previous frame's command on the next frame.
        miso_mode = 2;
        slv_resp  = 16'h0000;
        run_frame("slv1", 16'h0064, 16'h0000, 0, 1'b0);
        check("slv_captured", 32'(slv_rx), 32'h0064);
        slv_resp = (slv_rx == 16'h0064) ? 16'h00F1 : 16'h0000;
        run_frame("slv2", 16'h0000, 16'h00F1, 0, 1'b0);

        // start with new data while busy must be ignored.
        miso_mode = 0;
        run_frame("pulse", 16'h0F0F, 16'h0F0F, 50, 1'b0);

        // Reset in the middle of a frame (SCLK is high at cycle 60).
        @(negedge clk);
        bus.start   = 1'b1;
        bus.tx_data = 16'h3C3C;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 1;
        while (lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("pre_rst_sclk", 32'(bus.spi_sclk), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_csn",  32'(bus.spi_cs_n), 32'd1);
        check("mid_rst_sclk", 32'(bus.spi_sclk), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_rx",   32'(bus.rx_data), 32'd0);
        ndone = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (bus.done) ndone++;
        end
        check("mid_rst_nodone", 32'(ndone), 32'd0);
        run_frame("post_rst", 16'hC3A5, 16'hC3A5, 0, 1'b1);

        // start held high across three frames with MISO=1.
        miso_mode  = 1;
        miso_const = 1'b1;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.tx_data = 16'h1234;
        ndone    = 0;
        high_run = 0;
        gaps     = 0;
        seen_low = 1'b0;
        for (int n = 0; n < 800 && ndone < 3; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                ndone++;
                check($sformatf("held_rx%0d", ndone), 32'(bus.rx_data), 32'hFFFF);
                if (ndone == 3) bus.start = 1'b0;
            end
            if (bus.spi_cs_n) begin
                high_run++;
            end else begin
                if (seen_low && high_run > 0) begin
                    gaps++;
                    check($sformatf("held_gap%0d", gaps), 32'(high_run), 32'(DIV + 1));
                end
                high_run = 0;
                seen_low = 1'b1;
            end
        end
        bus.start = 1'b0;
        check("held_ndone", 32'(ndone), 32'd3);
        check("held_ngaps", 32'(gaps), 32'd2);
        repeat (20) @(posedge clk);
        #1;
        check("held_stopped", 32'(bus.busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter DATA_W, default 16: frame width in bits, range 8 to 32.
REQ-002 Parameter CLK_DIV, default 4: SCLK half-period in clk cycles, minimum 4.
REQ-003 clk  input  1  single system clock (CLOCK_50 domain); all state on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request a frame; sampled only in IDLE.
REQ-006 tx_data  input  DATA_W  word to shift out, captured on the accepted start cycle.
REQ-007 busy  output  1  high from the cycle after start is accepted until back in IDLE.
REQ-008 done  output  1  single-cycle pulse when rx_data becomes valid.
REQ-009 rx_data  output  DATA_W  last received word; holds its value until the next done.
REQ-010 spi_sclk  output  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-011 spi_mosi  output  1  serial data out, MSB first.
REQ-012 spi_miso  input  1  serial data in, asynchronous to clk.
REQ-013 spi_cs_n  output  1  active-low slave select.

Function
REQ-014 FSM states, in order: IDLE, SETUP, XFER, HOLD, GAP; GAP returns to IDLE.
REQ-015 IDLE with start=1: latch tx_data into the shift register and go to SETUP; spi_cs_n goes low and spi_mosi drives tx_data[DATA_W-1] on the next cycle.
REQ-016 SETUP lasts CLK_DIV cycles with spi_sclk low, then the FSM enters XFER.
REQ-017 XFER toggles spi_sclk every CLK_DIV cycles for exactly 2*DATA_W half-periods, starting with a rising edge and ending with spi_sclk low.
REQ-018 On each spi_sclk rising edge, shift the synchronized MISO bit into the receive register LSB.
REQ-019 On each spi_sclk falling edge except the last, spi_mosi advances to the next lower bit.
REQ-020 HOLD lasts CLK_DIV cycles with spi_cs_n low and spi_sclk low.
REQ-021 On HOLD exit: spi_cs_n goes high, rx_data loads the receive register, done pulses for 1 cycle, and the FSM enters GAP.
REQ-022 GAP lasts CLK_DIV cycles with spi_cs_n high and start ignored; this guarantees the minimum CS-high time between frames.
REQ-023 Latency: done is high exactly CLK_DIV*(2*DATA_W+2)+1 cycles after the cycle start is accepted (137 cycles at the defaults).
REQ-024 start while busy is ignored; tx_data changes after acceptance do not affect the frame.
REQ-025 start held high continuously: the next frame is accepted on the first IDLE cycle after GAP.
REQ-026 spi_miso passes through a 2-flop synchronizer before sampling; CLK_DIV>=4 keeps the slave response valid at the sampling edge.
REQ-027 Bit counter and divider counter wrap to 0 at each state change; neither counter may overflow for any legal parameter value.
REQ-028 In IDLE and GAP, spi_mosi is 0 and spi_sclk is 0.

Reset
REQ-029 reset_n low forces, without waiting for a clock edge: state IDLE, spi_cs_n=1, spi_sclk=0, spi_mosi=0, busy=0, done=0, rx_data=0, all counters and shift registers cleared.
REQ-030 Reset during a transfer aborts the frame with no done pulse; after release, the block accepts start on the first clk edge.

Structure
REQ-031 The shared package spi_pkg holds the state enum type spi_state_t and the default DATA_W and CLK_DIV constants.
REQ-032 The MISO synchronizer is a separate sub-module, sync2 (2 flops, async active-low reset, reset value 0).
REQ-033 Divider, bit counter and shift registers reside in spi_master; the block has no other sub-modules.

Verification
REQ-034 Loopback (spi_mosi tied to spi_miso), tx_data=0xA5C3 -> rx_data=0xA5C3; done exactly 137 cycles after start; 16 SCLK rising edges counted.
REQ-035 Slave model returns 0x00F1 for received 0x0064 on the following frame -> second frame rx_data=0x00F1 (241), and the slave captured 0x0064 (100).
REQ-036 start pulsed at cycle 50 of an active frame, with tx_data=0xFFFF -> no extra frame; the current MOSI stream is unchanged; exactly one done.
REQ-037 reset_n low at cycle 60 of a frame -> spi_cs_n=1 and spi_sclk=0 in the same cycle; no done; a new start after release gives a correct full frame.
REQ-038 start held high for 3 frames with spi_miso=1 -> rx_data=0xFFFF each frame; spi_cs_n high for at least CLK_DIV+1 cycles between frames.
